// File: rtl/ssd_scan_bcd_counter.sv
// ssd_scan_bcd_counter
// Multi-digit BCD up/down counter with parallel load, plus a time-multiplexed
// seven-segment driver. One digit is selected at a time (active-low one-hot
// d_sel) and its active-low segment pattern is presented on D_ssd. Leading
// zero digits can optionally be blanked. Display outputs are registered and
// lag the count/scan state by exactly one cycle.
module ssd_scan_bcd_counter #(
  parameter int DIGITS   = 4,  // 1..8
  parameter int STEP_DIV = 8,  // freq cycles per count step (>=1)
  parameter int SCAN_DIV = 4   // freq cycles per displayed digit (>=1)
) (
  input  logic                  freq,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   value,
  output logic                  wrap,
  output logic [DIGITS-1:0]     d_sel,
  output logic [14:0]           D_ssd
);

  localparam int VW     = 4 * DIGITS;
  localparam int STEP_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  localparam logic [VW-1:0] ALL_NINES = {DIGITS{4'h9}};
  localparam logic [14:0]   SSD_OFF   = 15'h7FFF;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Clamp every nibble to a legal BCD digit (values above 9 become 9).
  function automatic logic [VW-1:0] bcd_clamp(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] > 4'd9) r[4*k +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple BCD increment; carry out of the top digit is dropped.
  function automatic logic [VW-1:0] bcd_inc(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (carry) begin
        if (v[4*k +: 4] >= 4'd9) begin
          r[4*k +: 4] = 4'd0;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Ripple BCD decrement; borrow out of the top digit is dropped.
  function automatic logic [VW-1:0] bcd_dec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (borrow) begin
        if (v[4*k +: 4] == 4'd0) begin
          r[4*k +: 4] = 4'd9;
        end else begin
          r[4*k +: 4] = v[4*k +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Active-low a..g pattern for one BCD digit (a is the MSB).
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;  // unreachable: the count never holds non-BCD
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [STEP_W-1:0] step_pre_q, step_pre_d;
  logic [VW-1:0]     value_q,    value_d;
  logic              wrap_q,     wrap_d;
  logic [SCAN_W-1:0] scan_pre_q, scan_pre_d;
  logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
  logic [DIGITS-1:0] d_sel_q,    d_sel_d;
  logic [14:0]       ssd_q,      ssd_d;

  logic              step_fire;

  // Count path: load beats step beats hold; load also restarts the prescaler.
  // NOTE: every signal driven in always_comb gets a default at the top so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    step_pre_d = step_pre_q;
    value_d    = value_q;
    wrap_d     = 1'b0;
    step_fire  = 1'b0;

    if (load) begin
      value_d    = bcd_clamp(load_val);
      step_pre_d = '0;
    end else if (en) begin
      if (step_pre_q == STEP_LAST) begin
        step_pre_d = '0;
        step_fire  = 1'b1;
      end else begin
        step_pre_d = step_pre_q + STEP_W'(1);
      end
    end

    if (step_fire) begin
      if (up) begin
        value_d = bcd_inc(value_q);
        wrap_d  = (value_q == ALL_NINES);
      end else begin
        value_d = bcd_dec(value_q);
        wrap_d  = (value_q == '0);
      end
    end
  end

  // Scan path: free-running prescaler advances the selected digit, wrapping
  // from the top digit back to digit 0.
  always_comb begin
    scan_pre_d = scan_pre_q + SCAN_W'(1);
    scan_idx_d = scan_idx_q;
    if (scan_pre_q == SCAN_LAST) begin
      scan_pre_d = '0;
      scan_idx_d = (scan_idx_q == IDX_LAST) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  // Display path: pick the selected digit, decide blanking, decode segments.
  logic [3:0] cur_nib;
  logic       zero_above;
  logic       idx_lz;
  logic       blank;

  always_comb begin
    cur_nib    = 4'd0;
    zero_above = 1'b1;
    idx_lz     = 1'b0;
    // Walk from the top digit down; zero_above is true while every digit
    // from the top down to k is zero, i.e. digit k is a leading zero.
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above & (value_q[4*k +: 4] == 4'd0);
      if (scan_idx_q == IDX_W'(k)) begin
        cur_nib = value_q[4*k +: 4];
        idx_lz  = zero_above;
      end
    end
    // Digit 0 always shows, so a zero count still displays a single "0".
    blank   = blank_lz && (scan_idx_q != '0) && idx_lz;
    d_sel_d = ~(DIGITS'(1) << scan_idx_q);
    ssd_d   = blank ? SSD_OFF : {seg_decode(cur_nib), 8'hFF};
  end

  // State registers; reset returns counter, scanner and display to idle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge freq or negedge rst_n) begin
    if (!rst_n) begin
      step_pre_q <= '0;
      value_q    <= '0;
      wrap_q     <= 1'b0;
      scan_pre_q <= '0;
      scan_idx_q <= '0;
      d_sel_q    <= '1;
      ssd_q      <= SSD_OFF;
    end else begin
      step_pre_q <= step_pre_d;
      value_q    <= value_d;
      wrap_q     <= wrap_d;
      scan_pre_q <= scan_pre_d;
      scan_idx_q <= scan_idx_d;
      d_sel_q    <= d_sel_d;
      ssd_q      <= ssd_d;
    end
  end

  assign value = value_q;
  assign wrap  = wrap_q;
  assign d_sel = d_sel_q;
  assign D_ssd = ssd_q;

endmodule

// File: tb/tb_ssd_scan_bcd_counter.sv
// Testbench for ssd_scan_bcd_counter (DIGITS=4, STEP_DIV=2, SCAN_DIV=4).
// Hand-written sequences and a load table check literal values; a decimal
// integer reference model is compared against every output on every cycle,
// including a long randomized run.
module tb_ssd_scan_bcd_counter;

  localparam int DIGITS   = 4;
  localparam int STEP_DIV = 2;
  localparam int SCAN_DIV = 4;
  localparam int W        = 4 * DIGITS;

  logic              freq     = 1'b0;
  logic              rst_n    = 1'b0;
  logic              en       = 1'b0;
  logic              up       = 1'b0;
  logic              load     = 1'b0;
  logic [W-1:0]      load_val = '0;
  logic              blank_lz = 1'b0;
  logic [W-1:0]      value;
  logic              wrap;
  logic [DIGITS-1:0] d_sel;
  logic [14:0]       D_ssd;

  ssd_scan_bcd_counter #(
    .DIGITS   (DIGITS),
    .STEP_DIV (STEP_DIV),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .freq     (freq),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .blank_lz (blank_lz),
    .value    (value),
    .wrap     (wrap),
    .d_sel    (d_sel),
    .D_ssd    (D_ssd)
  );

  always #5 freq = ~freq;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: the count is a plain decimal integer modulo 10^DIGITS,
  // the scanned digit is derived from the number of edges since reset.
  // ---------------------------------------------------------------------------
  int                m_cnt;
  int                m_pre;
  int                m_cyc;
  logic              m_wrap;
  logic [DIGITS-1:0] m_dsel;
  logic [14:0]       m_ssd;

  function automatic int pow10(input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * 10;
    return r;
  endfunction

  localparam int MAXV = 10000;  // 10^DIGITS

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      default: return 7'b0000100;
    endcase
  endfunction

  function automatic int clamp_dec(input logic [W-1:0] v);
    int s = 0;
    int n;
    for (int k = 0; k < DIGITS; k++) begin
      n = int'(v[4*k +: 4]);
      if (n > 9) n = 9;
      s = s + n * pow10(k);
    end
    return s;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int n);
    logic [W-1:0] r = '0;
    for (int k = 0; k < DIGITS; k++) r[4*k +: 4] = 4'((n / pow10(k)) % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    m_pre  = 0;
    m_cyc  = 0;
    m_wrap = 1'b0;
    m_dsel = '1;
    m_ssd  = 15'h7FFF;
  endtask

  task automatic model_edge();
    int idx;
    int dig;
    idx    = (m_cyc / SCAN_DIV) % DIGITS;
    dig    = (m_cnt / pow10(idx)) % 10;
    m_dsel = ~(DIGITS'(1) << idx);
    if (blank_lz && idx > 0 && m_cnt < pow10(idx)) m_ssd = 15'h7FFF;
    else                                            m_ssd = {seg(dig), 8'hFF};
    m_wrap = 1'b0;
    if (load) begin
      m_cnt = clamp_dec(load_val);
      m_pre = 0;
    end else if (en) begin
      if (m_pre == STEP_DIV - 1) begin
        m_pre = 0;
        if (up) begin
          m_wrap = (m_cnt == MAXV - 1);
          m_cnt  = (m_cnt + 1) % MAXV;
        end else begin
          m_wrap = (m_cnt == 0);
          m_cnt  = (m_cnt + MAXV - 1) % MAXV;
        end
      end else begin
        m_pre++;
      end
    end
    m_cyc = (m_cyc + 1) % (SCAN_DIV * DIGITS);
  endtask

  task automatic cmp_model();
    check("model_value", value, to_bcd(m_cnt));
    check("model_wrap",  wrap,  m_wrap);
    check("model_dsel",  d_sel, m_dsel);
    check("model_ssd",   D_ssd, m_ssd);
  endtask

  // One clock: model follows the edge, outputs compared 1 time unit later,
  // returns at the falling edge where the next inputs are driven.
  task automatic cycle();
    @(posedge freq);
    if (rst_n) model_edge();
    #1;
    cmp_model();
    @(negedge freq);
  endtask

  // Index of the active (low) bit of d_sel.
  function automatic int sel_idx(input logic [DIGITS-1:0] s);
    int r = 0;
    for (int i = 0; i < DIGITS; i++) if (s[i] == 1'b0) r = i;
    return r;
  endfunction

  typedef struct {
    logic [W-1:0] lv;
    logic [W-1:0] exp_value;
  } load_vec_t;

  load_vec_t    load_tab [6];
  logic [3:0]   t1_dsel  [4];
  logic [14:0]  exp_blank[4];
  logic [14:0]  exp_plain[4];

  initial begin
    load_tab[0] = '{lv: 16'h0F3A, exp_value: 16'h0939};
    load_tab[1] = '{lv: 16'hFFFF, exp_value: 16'h9999};
    load_tab[2] = '{lv: 16'h1234, exp_value: 16'h1234};
    load_tab[3] = '{lv: 16'hA0B0, exp_value: 16'h9090};
    load_tab[4] = '{lv: 16'h9C07, exp_value: 16'h9907};
    load_tab[5] = '{lv: 16'h0000, exp_value: 16'h0000};
    t1_dsel   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    // Count 0042: digit0 "2", digit1 "4", digits 2/3 blank or "0".
    exp_blank = '{15'h12FF, 15'h4CFF, 15'h7FFF, 15'h7FFF};
    exp_plain = '{15'h12FF, 15'h4CFF, 15'h01FF, 15'h01FF};

    model_reset();
    repeat (2) @(negedge freq);

    // Reset state.
    check("rst_value", value, 16'h0000);
    check("rst_wrap",  wrap,  1'b0);
    check("rst_dsel",  d_sel, 4'hF);
    check("rst_ssd",   D_ssd, 15'h7FFF);
    rst_n = 1'b1;

    // Idle scan after reset.
    for (int c = 1; c <= 20; c++) begin
      cycle();
      check("t1_dsel", d_sel, t1_dsel[((c - 1) / SCAN_DIV) % DIGITS]);
      check("t1_value", value, 16'h0000);
      if (d_sel == 4'b1110) check("t1_ssd0", D_ssd, 15'h01FF);
    end

    // Count up across the all-nines boundary.
    load_val = 16'h9998;
    load     = 1'b1;
    cycle();
    check("t2_load", value, 16'h9998);
    load = 1'b0; en = 1'b1; up = 1'b1;
    cycle();
    check("t2_c1", value, 16'h9998);
    cycle();
    check("t2_9999", value, 16'h9999);
    check("t2_nowrap", wrap, 1'b0);
    cycle();
    cycle();
    check("t2_0000", value, 16'h0000);
    check("t2_wrap", wrap, 1'b1);
    cycle();
    check("t2_wrap_end", wrap, 1'b0);

    // Count down across zero, then freeze.
    en = 1'b0; load_val = 16'h0000; load = 1'b1;
    cycle();
    load = 1'b0; en = 1'b1; up = 1'b0;
    cycle();
    cycle();
    check("t3_9999", value, 16'h9999);
    check("t3_wrap", wrap, 1'b1);
    en = 1'b0;
    repeat (10) cycle();
    check("t3_frozen", value, 16'h9999);
    check("t3_wrap_low", wrap, 1'b0);

    // Load table with nibble clamping.
    for (int i = 0; i < 6; i++) begin
      load_val = load_tab[i].lv;
      load     = 1'b1;
      cycle();
      load = 1'b0;
      check("t4_load", value, load_tab[i].exp_value);
      check("t4_wrap", wrap, 1'b0);
    end

    // Leading-zero blanking on 0042.
    load_val = 16'h0042; load = 1'b1;
    cycle();
    load = 1'b0; blank_lz = 1'b1;
    for (int c = 0; c < 16; c++) begin
      cycle();
      check("t5_blank_ssd", D_ssd, exp_blank[sel_idx(d_sel)]);
    end
    blank_lz = 1'b0;
    for (int c = 0; c < 16; c++) begin
      cycle();
      check("t5_plain_ssd", D_ssd, exp_plain[sel_idx(d_sel)]);
    end

    // Asynchronous reset mid-count and mid-scan.
    load_val = 16'h1234; load = 1'b1;
    cycle();
    load = 1'b0; en = 1'b1; up = 1'b1;
    repeat (5) cycle();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_value", value, 16'h0000);
    check("t6_rst_wrap",  wrap,  1'b0);
    check("t6_rst_dsel",  d_sel, 4'hF);
    check("t6_rst_ssd",   D_ssd, 15'h7FFF);
    @(negedge freq);
    cycle();
    cycle();
    rst_n = 1'b1; en = 1'b0;
    cycle();
    check("t6_first_dsel", d_sel, 4'b1110);
    check("t6_first_ssd",  D_ssd, 15'h01FF);

    // load together with en: load wins and restarts the step prescaler.
    en = 1'b1; up = 1'b1; load = 1'b1; load_val = 16'h0005;
    cycle();
    check("t6_ld_a", value, 16'h0005);
    load = 1'b0;
    cycle();
    check("t6_ld_a_hold", value, 16'h0005);
    load = 1'b1; load_val = 16'h0007;
    cycle();
    check("t6_ld_b", value, 16'h0007);
    load = 1'b0;
    cycle();
    check("t6_ld_b_hold", value, 16'h0007);
    cycle();
    check("t6_ld_b_step", value, 16'h0008);

    // Randomized run against the model.
    for (int c = 0; c < 600; c++) begin
      load = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0: load_val = W'($urandom);
        1: load_val = 16'h9999;
        2: load_val = 16'h0000;
        default: load_val = ($urandom_range(1) == 1) ? 16'h9998 : 16'h0001;
      endcase
      en = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) up = ~up;
      if ($urandom_range(15) == 0) blank_lz = ~blank_lz;
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
